// File: rtl/wb_write_sequencer_pkg.sv
// Shared types for the write-back sequencer.
// State encoding and the hardwired zero register.
package wb_write_sequencer_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WRITE_B = 1'b1
  } wb_state_t;

  localparam int unsigned ZERO_REG = 0;

  function automatic logic is_zero_reg(
    input logic [31:0] addr
  );
    return addr == 32'(ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: picks ALU or load data and
// serialises dual writes onto one register-file port.
module wb_write_sequencer
  import wb_write_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write_back_mux_sel_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     hi_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_data_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr_in,
  input  logic                      reg_a_wr_en_in,
  input  logic                      reg_b_wr_en_in,
  output logic                      rf_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     rf_wr_data_out,
  output logic                      stall_out,
  output logic                      mem_data_ack_out
);

  wb_state_t state;
  wb_state_t next_state;

  logic [REG_ADDR_WIDTH-1:0] b_addr_q;
  logic [DATA_WIDTH-1:0]     b_data_q;

  logic                      idle;
  logic                      load_wait;
  logic [DATA_WIDTH-1:0]     data_a;

  logic                      issue;
  logic                      latch_b;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;

  assign idle   = (state == S_IDLE);
  assign data_a = write_back_mux_sel_in
                ? mem_data_in
                : alu_data_in;

  // A load whose data has not arrived holds the instruction
  assign load_wait = idle
                   & reg_a_wr_en_in
                   & write_back_mux_sel_in
                   & ~mem_data_valid_in;

  // Stall covers the load wait and the second write cycle
  always_comb begin
    stall_out = ~idle | load_wait;
  end

  // Load data is consumed in the cycle write A is issued
  always_comb begin
    mem_data_ack_out = idle
                     & reg_a_wr_en_in
                     & write_back_mux_sel_in
                     & mem_data_valid_in;
  end

  // Next-state: a dual write spends one extra cycle on B
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (!load_wait &&
            reg_a_wr_en_in &&
            reg_b_wr_en_in) begin
          next_state = S_WRITE_B;
        end
      end
      S_WRITE_B: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output decode: which write (if any) goes out this cycle
  always_comb begin
    issue   = 1'b0;
    latch_b = 1'b0;
    wr_addr = b_addr_q;
    wr_data = b_data_q;
    unique case (state)
      S_IDLE: begin
        if (load_wait) begin
          issue = 1'b0;
        end else if (reg_a_wr_en_in) begin
          issue   = 1'b1;
          wr_addr = reg_a_wr_addr_in;
          wr_data = data_a;
          latch_b = reg_b_wr_en_in;
        end else if (reg_b_wr_en_in) begin
          issue   = 1'b1;
          wr_addr = reg_b_wr_addr_in;
          wr_data = hi_data_in;
        end
      end
      S_WRITE_B: begin
        issue = 1'b1;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  // State, B latch and registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      b_addr_q       <= '0;
      b_data_q       <= '0;
      rf_wr_en_out   <= 1'b0;
      rf_wr_addr_out <= '0;
      rf_wr_data_out <= '0;
    end else begin
      state        <= next_state;
      rf_wr_en_out <= issue &
                      ~is_zero_reg(32'(wr_addr));
      if (issue) begin
        rf_wr_addr_out <= wr_addr;
        rf_wr_data_out <= wr_data;
      end
      if (latch_b) begin
        b_addr_q <= reg_b_wr_addr_in;
        b_data_q <= hi_data_in;
      end
    end
  end

endmodule
